// File: rtl/foc_sched_pkg.sv
// Shared types and defaults for the FOC current-loop scheduler.
// State enum, default word width/timeout and overrun counter width.
package foc_sched_pkg;

  localparam int FOC_DATA_WIDTH     = 16;
  localparam int FOC_TIMEOUT_CYCLES = 64;
  localparam int OVERRUN_CNT_W      = 16;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_SAMPLE = 3'd1,
    LAUNCH      = 3'd2,
    WAIT_RESULT = 3'd3,
    DONE        = 3'd4
  } state_t;

endpackage

// File: rtl/foc_sched_timeout_cnt.sv
// Result-wait timer: cleared on launch, counts while enabled, flags expiry
// when the count reaches TIMEOUT_CYCLES-1 (holds there until cleared).
module foc_sched_timeout_cnt
  import foc_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = FOC_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign expire = (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/foc_current_loop_scheduler.sv
// Sequences one FOC current-loop iteration per PWM tick: sample, launch the
// clark/park datapath, collect Id/Iq. Optional macro FOC_SCHED_OVERRUN_CNT_EN.
module foc_current_loop_scheduler
  import foc_sched_pkg::*;
#(
  parameter int DATA_WIDTH     = FOC_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = FOC_TIMEOUT_CYCLES
) (
  input  logic                         sys_clk,
  input  logic                         reset,
  input  logic                         pwm_tick_in,
  input  logic                         sample_valid_in,
  input  logic signed [DATA_WIDTH-1:0] phase_a_current_in,
  input  logic signed [DATA_WIDTH-1:0] phase_b_current_in,
  input  logic signed [DATA_WIDTH-1:0] angle_sin_in,
  input  logic signed [DATA_WIDTH-1:0] angle_cos_in,
  output logic signed [DATA_WIDTH-1:0] phase_a_current_out,
  output logic signed [DATA_WIDTH-1:0] phase_b_current_out,
  output logic signed [DATA_WIDTH-1:0] angle_sin_out,
  output logic signed [DATA_WIDTH-1:0] angle_cos_out,
  output logic                         transaction_enable_out,
  input  logic signed [DATA_WIDTH-1:0] current_d_in,
  input  logic signed [DATA_WIDTH-1:0] current_q_in,
  input  logic                         transaction_valid_in,
  output logic signed [DATA_WIDTH-1:0] current_d_out,
  output logic signed [DATA_WIDTH-1:0] current_q_out,
  output logic                         loop_done_out,
  output logic                         busy_out,
  input  logic                         err_clr_in,
  output logic                         timeout_err_out
`ifdef FOC_SCHED_OVERRUN_CNT_EN
  ,
  output logic [OVERRUN_CNT_W-1:0]     overrun_cnt_out
`endif
);

  state_t state, state_nxt;

  logic valid_p1;
  logic valid_edge;
  logic timer_clr;
  logic timer_en;
  logic timer_expire;
  logic latch_sample;
  logic latch_result;
  logic set_timeout;

  // Only a fresh rising edge of the datapath valid is a result.
  assign valid_edge = transaction_valid_in & ~valid_p1;

  foc_sched_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (sys_clk),
    .rst    (reset),
    .clear  (timer_clr),
    .enable (timer_en),
    .expire (timer_expire)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      valid_p1 <= 1'b0;
    end else begin
      state    <= state_nxt;
      valid_p1 <= transaction_valid_in;
    end
  end

  always_comb begin
    state_nxt    = state;
    latch_sample = 1'b0;
    latch_result = 1'b0;
    set_timeout  = 1'b0;
    timer_clr    = 1'b0;
    timer_en     = 1'b0;
    case (state)
      IDLE: begin
        if (pwm_tick_in) state_nxt = WAIT_SAMPLE;
      end
      WAIT_SAMPLE: begin
        if (sample_valid_in) begin
          latch_sample = 1'b1;
          state_nxt    = LAUNCH;
        end
      end
      LAUNCH: begin
        timer_clr = 1'b1;
        state_nxt = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        timer_en = 1'b1;
        // A result edge in the expiry cycle still counts as success.
        if (valid_edge) begin
          latch_result = 1'b1;
          state_nxt    = DONE;
        end else if (timer_expire) begin
          set_timeout = 1'b1;
          state_nxt   = IDLE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign transaction_enable_out = (state == LAUNCH);
  assign loop_done_out          = (state == DONE);
  assign busy_out               = (state != IDLE);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      phase_a_current_out <= '0;
      phase_b_current_out <= '0;
      angle_sin_out       <= '0;
      angle_cos_out       <= '0;
    end else if (latch_sample) begin
      phase_a_current_out <= phase_a_current_in;
      phase_b_current_out <= phase_b_current_in;
      angle_sin_out       <= angle_sin_in;
      angle_cos_out       <= angle_cos_in;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      current_d_out <= '0;
      current_q_out <= '0;
    end else if (latch_result) begin
      current_d_out <= current_d_in;
      current_q_out <= current_q_in;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      timeout_err_out <= 1'b0;
    end else if (set_timeout) begin
      timeout_err_out <= 1'b1;
    end else if (err_clr_in) begin
      timeout_err_out <= 1'b0;
    end
  end

`ifdef FOC_SCHED_OVERRUN_CNT_EN
  logic [OVERRUN_CNT_W-1:0] overrun_cnt;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      overrun_cnt <= '0;
    end else if (err_clr_in) begin
      overrun_cnt <= '0;
    end else if (pwm_tick_in && (state != IDLE) && (overrun_cnt != '1)) begin
      overrun_cnt <= overrun_cnt + OVERRUN_CNT_W'(1);
    end
  end

  assign overrun_cnt_out = overrun_cnt;
`endif

endmodule

// File: tb/tb_foc_current_loop_scheduler.sv
// Self-checking bench for foc_current_loop_scheduler: cycle-level expectations
// derived from the scheduling rules, randomized operands/results/delays.
module tb_foc_current_loop_scheduler;

  logic               sys_clk = 1'b0;
  logic               reset;
  logic               pwm_tick_in;
  logic               sample_valid_in;
  logic signed [15:0] phase_a_current_in, phase_b_current_in;
  logic signed [15:0] angle_sin_in, angle_cos_in;
  logic signed [15:0] phase_a_current_out, phase_b_current_out;
  logic signed [15:0] angle_sin_out, angle_cos_out;
  logic               transaction_enable_out;
  logic signed [15:0] current_d_in, current_q_in;
  logic               transaction_valid_in;
  logic signed [15:0] current_d_out, current_q_out;
  logic               loop_done_out;
  logic               busy_out;
  logic               err_clr_in;
  logic               timeout_err_out;
`ifdef FOC_SCHED_OVERRUN_CNT_EN
  logic [15:0]        overrun_cnt_out;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state: what each latched output should hold.
  logic signed [15:0] m_a, m_b, m_s, m_c, m_d, m_q;
  logic               m_err;
  int                 m_ovr;

  always #5 sys_clk = ~sys_clk;

  foc_current_loop_scheduler dut (
    .sys_clk                (sys_clk),
    .reset                  (reset),
    .pwm_tick_in            (pwm_tick_in),
    .sample_valid_in        (sample_valid_in),
    .phase_a_current_in     (phase_a_current_in),
    .phase_b_current_in     (phase_b_current_in),
    .angle_sin_in           (angle_sin_in),
    .angle_cos_in           (angle_cos_in),
    .phase_a_current_out    (phase_a_current_out),
    .phase_b_current_out    (phase_b_current_out),
    .angle_sin_out          (angle_sin_out),
    .angle_cos_out          (angle_cos_out),
    .transaction_enable_out (transaction_enable_out),
    .current_d_in           (current_d_in),
    .current_q_in           (current_q_in),
    .transaction_valid_in   (transaction_valid_in),
    .current_d_out          (current_d_out),
    .current_q_out          (current_q_out),
    .loop_done_out          (loop_done_out),
    .busy_out               (busy_out),
    .err_clr_in             (err_clr_in),
    .timeout_err_out        (timeout_err_out)
`ifdef FOC_SCHED_OVERRUN_CNT_EN
    ,
    .overrun_cnt_out        (overrun_cnt_out)
`endif
  );

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic junk_ops();
    phase_a_current_in = 16'($urandom);
    phase_b_current_in = 16'($urandom);
    angle_sin_in       = 16'($urandom);
    angle_cos_in       = 16'($urandom);
  endtask

  // Tick then sample; returns with the LAUNCH cycle being observed.
  task automatic start_txn(input logic signed [15:0] a, b, s, c);
    pwm_tick_in = 1'b1;
    cyc();
    pwm_tick_in        = 1'b0;
    phase_a_current_in = a;
    phase_b_current_in = b;
    angle_sin_in       = s;
    angle_cos_in       = c;
    sample_valid_in    = 1'b1;
    cyc();
    sample_valid_in = 1'b0;
    junk_ops();
    m_a = a; m_b = b; m_s = s; m_c = c;
  endtask

  // Full transaction; delay = cycles from LAUNCH to the valid edge (1..64).
  task automatic run_txn(input string tag, input logic signed [15:0] a, b, s, c, d, q,
                         input int pre, input int delay);
    junk_ops();
    pwm_tick_in     = 1'b1;
    sample_valid_in = 1'b1;
    cyc();
    pwm_tick_in     = 1'b0;
    sample_valid_in = 1'b0;
    checks++;
    if ({busy_out, transaction_enable_out} !== 2'b10) begin
      failures++;
      $display("FAIL %s_tick busy/en got=%b exp=10", tag, {busy_out, transaction_enable_out});
    end
    checks++;
    if ({phase_a_current_out, phase_b_current_out, angle_sin_out, angle_cos_out} !== {m_a, m_b, m_s, m_c}) begin
      failures++;
      $display("FAIL %s_tick_ops got=%h exp=%h", tag,
               {phase_a_current_out, phase_b_current_out, angle_sin_out, angle_cos_out}, {m_a, m_b, m_s, m_c});
    end
    for (int i = 0; i < pre; i++) begin
      cyc();
      checks++;
      if ({busy_out, transaction_enable_out} !== 2'b10) begin
        failures++;
        $display("FAIL %s_wait_sample got=%b exp=10", tag, {busy_out, transaction_enable_out});
      end
    end
    phase_a_current_in = a;
    phase_b_current_in = b;
    angle_sin_in       = s;
    angle_cos_in       = c;
    sample_valid_in    = 1'b1;
    cyc();
    sample_valid_in = 1'b0;
    junk_ops();
    m_a = a; m_b = b; m_s = s; m_c = c;
    checks++;
    if (transaction_enable_out !== 1'b1) begin
      failures++;
      $display("FAIL %s_enable got=%b exp=1", tag, transaction_enable_out);
    end
    checks++;
    if ({phase_a_current_out, phase_b_current_out, angle_sin_out, angle_cos_out} !== {m_a, m_b, m_s, m_c}) begin
      failures++;
      $display("FAIL %s_ops got=%h exp=%h", tag,
               {phase_a_current_out, phase_b_current_out, angle_sin_out, angle_cos_out}, {m_a, m_b, m_s, m_c});
    end
    for (int i = 0; i < delay; i++) begin
      cyc();
      checks++;
      if ({transaction_enable_out, loop_done_out, busy_out, timeout_err_out} !== {3'b001, m_err}) begin
        failures++;
        $display("FAIL %s_wait_result cyc=%0d got=%b exp=%b", tag, i,
                 {transaction_enable_out, loop_done_out, busy_out, timeout_err_out}, {3'b001, m_err});
      end
    end
    current_d_in         = d;
    current_q_in         = q;
    transaction_valid_in = 1'b1;
    cyc();
    m_d = d; m_q = q;
    checks++;
    if (loop_done_out !== 1'b1) begin
      failures++;
      $display("FAIL %s_done got=%b exp=1", tag, loop_done_out);
    end
    checks++;
    if ({current_d_out, current_q_out} !== {m_d, m_q}) begin
      failures++;
      $display("FAIL %s_dq got=%h exp=%h", tag, {current_d_out, current_q_out}, {m_d, m_q});
    end
    current_d_in = 16'($urandom);
    current_q_in = 16'($urandom);
    cyc();
    transaction_valid_in = 1'b0;
    checks++;
    if ({loop_done_out, busy_out, timeout_err_out, current_d_out, current_q_out} !== {2'b00, m_err, m_d, m_q}) begin
      failures++;
      $display("FAIL %s_after got=%h exp=%h", tag,
               {loop_done_out, busy_out, timeout_err_out, current_d_out, current_q_out}, {2'b00, m_err, m_d, m_q});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pwm_tick_in = 1'b0; sample_valid_in = 1'b0; transaction_valid_in = 1'b0; err_clr_in = 1'b0;
    junk_ops();
    current_d_in = 16'($urandom);
    current_q_in = 16'($urandom);
    m_a = '0; m_b = '0; m_s = '0; m_c = '0; m_d = '0; m_q = '0; m_err = 1'b0; m_ovr = 0;
    repeat (3) cyc();
    checks++;
    if ({transaction_enable_out, loop_done_out, busy_out, timeout_err_out} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {transaction_enable_out, loop_done_out, busy_out, timeout_err_out});
    end
    checks++;
    if ({phase_a_current_out, phase_b_current_out, angle_sin_out, angle_cos_out, current_d_out, current_q_out} !== 96'd0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {phase_a_current_out, phase_b_current_out, angle_sin_out,
               angle_cos_out, current_d_out, current_q_out});
    end
    reset = 1'b0;
    sample_valid_in = 1'b1;
    cyc();
    sample_valid_in = 1'b0;
    checks++;
    if ({busy_out, phase_a_current_out} !== 17'd0) begin
      failures++;
      $display("FAIL idle_ignores_sample got=%h exp=0", {busy_out, phase_a_current_out});
    end
  endtask

  task automatic test_nominal();
    run_txn("nominal", 16384, -8192, 0, 32767, 1000, -2000, 1, 10);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      run_txn("random", 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), $urandom_range(3, 0), $urandom_range(64, 1));
    end
  endtask

  task automatic test_edge_at_timeout();
    run_txn("edge_at_timeout", 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            -32768, 32767, 0, 64);
  endtask

  task automatic test_timeout(input logic clr_at_expiry);
    start_txn(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    for (int i = 0; i < 64; i++) begin
      cyc();
      checks++;
      if ({busy_out, timeout_err_out, loop_done_out} !== 3'b100) begin
        failures++;
        $display("FAIL timeout_wait cyc=%0d got=%b exp=100", i, {busy_out, timeout_err_out, loop_done_out});
      end
    end
    err_clr_in = clr_at_expiry;
    cyc();
    err_clr_in = 1'b0;
    m_err = 1'b1;
    if (clr_at_expiry) m_ovr = 0;
    checks++;
    if ({busy_out, timeout_err_out, loop_done_out} !== 3'b010) begin
      failures++;
      $display("FAIL timeout_flag clr=%0b got=%b exp=010", clr_at_expiry, {busy_out, timeout_err_out, loop_done_out});
    end
    repeat (2) cyc();
    checks++;
    if ({loop_done_out, current_d_out, current_q_out} !== {1'b0, m_d, m_q}) begin
      failures++;
      $display("FAIL timeout_dq got=%h exp=%h", {loop_done_out, current_d_out, current_q_out}, {1'b0, m_d, m_q});
    end
    err_clr_in = 1'b1;
    cyc();
    err_clr_in = 1'b0;
    m_err = 1'b0;
    m_ovr = 0;
    checks++;
    if (timeout_err_out !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear got=%b exp=0", timeout_err_out);
    end
  endtask

  task automatic test_stale_valid();
    current_d_in = 16'sd111;
    current_q_in = 16'sd222;
    transaction_valid_in = 1'b1;
    start_txn(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if ({loop_done_out, busy_out} !== 2'b01) begin
        failures++;
        $display("FAIL stale_level_accepted cyc=%0d got=%b exp=01", i, {loop_done_out, busy_out});
      end
    end
    transaction_valid_in = 1'b0;
    repeat (5) cyc();
    current_d_in = -16'sd1234;
    current_q_in = 16'sd4321;
    transaction_valid_in = 1'b1;
    cyc();
    m_d = -16'sd1234; m_q = 16'sd4321;
    checks++;
    if ({loop_done_out, current_d_out, current_q_out} !== {1'b1, m_d, m_q}) begin
      failures++;
      $display("FAIL stale_fresh_edge got=%h exp=%h", {loop_done_out, current_d_out, current_q_out}, {1'b1, m_d, m_q});
    end
    transaction_valid_in = 1'b0;
    cyc();
  endtask

  task automatic test_overrun();
    start_txn(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    repeat (2) cyc();
    for (int i = 0; i < 3; i++) begin
      pwm_tick_in = 1'b1;
      cyc();
      pwm_tick_in = 1'b0;
      m_ovr++;
      cyc();
      checks++;
      if ({busy_out, transaction_enable_out, loop_done_out} !== 3'b100) begin
        failures++;
        $display("FAIL overrun_tick cyc=%0d got=%b exp=100", i, {busy_out, transaction_enable_out, loop_done_out});
      end
    end
    current_d_in = 16'sd77;
    current_q_in = -16'sd77;
    transaction_valid_in = 1'b1;
    cyc();
    transaction_valid_in = 1'b0;
    m_d = 16'sd77; m_q = -16'sd77;
    checks++;
    if ({loop_done_out, current_d_out, current_q_out} !== {1'b1, m_d, m_q}) begin
      failures++;
      $display("FAIL overrun_done got=%h exp=%h", {loop_done_out, current_d_out, current_q_out}, {1'b1, m_d, m_q});
    end
    repeat (3) cyc();
    checks++;
    if ({busy_out, loop_done_out} !== 2'b00) begin
      failures++;
      $display("FAIL overrun_no_restart got=%b exp=00", {busy_out, loop_done_out});
    end
`ifdef FOC_SCHED_OVERRUN_CNT_EN
    checks++;
    if (overrun_cnt_out !== 16'(m_ovr)) begin
      failures++;
      $display("FAIL overrun_cnt got=%0d exp=%0d", overrun_cnt_out, m_ovr);
    end
`endif
  endtask

  task automatic test_reset_mid();
    start_txn(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    repeat (3) cyc();
    reset = 1'b1;
    #1;
    m_a = '0; m_b = '0; m_s = '0; m_c = '0; m_d = '0; m_q = '0; m_err = 1'b0; m_ovr = 0;
    checks++;
    if ({busy_out, transaction_enable_out, loop_done_out} !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid_async got=%b exp=000", {busy_out, transaction_enable_out, loop_done_out});
    end
    cyc();
    reset = 1'b0;
    current_d_in = 16'sd500;
    current_q_in = 16'sd600;
    transaction_valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if ({loop_done_out, busy_out, timeout_err_out} !== 3'b000) begin
        failures++;
        $display("FAIL reset_mid_no_done cyc=%0d got=%b exp=000", i, {loop_done_out, busy_out, timeout_err_out});
      end
    end
    transaction_valid_in = 1'b0;
    checks++;
    if ({phase_a_current_out, phase_b_current_out, angle_sin_out, angle_cos_out, current_d_out, current_q_out} !== 96'd0) begin
      failures++;
      $display("FAIL reset_mid_data got=%h exp=0", {phase_a_current_out, phase_b_current_out, angle_sin_out,
               angle_cos_out, current_d_out, current_q_out});
    end
    cyc();
    run_txn("restart", 16'sd100, -16'sd200, 16'sd300, -16'sd400, 16'sd5, -16'sd6, 0, 4);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_random();
    test_edge_at_timeout();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_stale_valid();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
